// File: rtl/iccm_ctrl_pkg.sv
// ============================================================================
// Module : iccm_ctrl_pkg
// Brief  : Shared types and defaults for the ICCM program loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package iccm_ctrl_pkg;

    localparam int          c_ADDR_W   = 12;
    localparam int          c_DATA_W   = 32;
    localparam logic [31:0] c_END_WORD = 32'h0000_0FFF;

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage : iccm_ctrl_pkg

`default_nettype wire

// File: rtl/iccm_byte_packer.sv
// ============================================================================
// Module : iccm_byte_packer
// Brief  : Packs a little-endian byte stream into 32-bit words.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iccm_byte_packer
    import iccm_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [7:0]          i_byte,
    input  logic                i_valid,
    output logic [c_DATA_W-1:0] o_word,
    output logic                o_word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_low;
    logic        w_take;

    assign w_take       = i_en & i_valid;
    // Byte 3 is presented straight from the input so the word completes on its edge.
    assign o_word_valid = w_take && (r_cnt == 2'd3);
    assign o_word       = {i_byte, r_low};

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 2'd0;
            r_low <= 24'd0;
        end else if (w_take) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0:    r_low[7:0]   <= i_byte;
                2'd1:    r_low[15:8]  <= i_byte;
                2'd2:    r_low[23:16] <= i_byte;
                default: ;
            endcase
        end
    end

endmodule : iccm_byte_packer

`default_nettype wire

// File: rtl/iccm_ctrl.sv
// ============================================================================
// Module : iccm_ctrl
// Brief  : Boot loader writing UART bytes into ICCM, releasing program reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module iccm_ctrl
    import iccm_ctrl_pkg::*;
#(
    parameter int                   ADDR_W   = c_ADDR_W,
    parameter logic [c_DATA_W-1:0]  END_WORD = c_END_WORD
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          rx_byte_i,
    input  logic                rx_valid_i,
    input  logic                reprog_i,
    output logic [ADDR_W-1:0]   iccm_addr_o,
    output logic [c_DATA_W-1:0] iccm_wdata_o,
    output logic                iccm_we_o,
    output logic                prog_rst_no,
    output logic                done_o
);

    localparam logic [ADDR_W-1:0] c_ADDR_LAST = '1;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_DATA_W-1:0] r_wdata;
    logic                r_we;
    logic                r_done;

    logic [c_DATA_W-1:0] w_word;
    logic                w_word_valid;
    logic                w_wr_word;
    logic                w_full;
    logic                w_reprog;

    iccm_byte_packer u_packer (
        .clk          (clk_i),
        .rst          (rst_i),
        .i_clr        (w_reprog),
        .i_en         (r_state == ST_LOAD),
        .i_byte       (rx_byte_i),
        .i_valid      (rx_valid_i),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wr_word   = 1'b0;
        w_full      = 1'b0;
        w_reprog    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                if (w_word_valid) begin
                    if (w_word == END_WORD) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_wr_word = 1'b1;
                    end
                end
                // Strobe to the last address closes loading instead of wrapping.
                if (r_we && (r_addr == c_ADDR_LAST)) begin
                    w_full      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (reprog_i) begin
                    w_reprog    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_LOAD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= w_wr_word;
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_wr_word) begin
                r_wdata <= w_word;
            end
            if (w_reprog) begin
                r_addr <= '0;
            end else if (r_we && !w_full && (r_state == ST_LOAD)) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign iccm_addr_o  = r_addr;
    assign iccm_wdata_o = r_wdata;
    assign iccm_we_o    = r_we;
    assign prog_rst_no  = r_done;
    assign done_o       = r_done;

endmodule : iccm_ctrl

`default_nettype wire

// File: tb/tb_iccm_ctrl.sv
// ============================================================================
// Module : tb_iccm_ctrl
// Brief  : Scoreboard bench for the ICCM program loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_iccm_ctrl;

    localparam int          c_WORDS = 4096;
    localparam logic [31:0] c_END   = 32'h0000_0FFF;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  rx_byte_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        reprog_i = 1'b0;
    logic [11:0] iccm_addr_o;
    logic [31:0] iccm_wdata_o;
    logic        iccm_we_o;
    logic        prog_rst_no;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    // Reference model: collected bytes, words written so far, loading finished.
    logic [7:0]  m_bytes[$];
    int          m_count = 0;
    bit          m_done  = 1'b0;
    logic [43:0] exp_q[$];

    iccm_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rx_byte_i    (rx_byte_i),
        .rx_valid_i   (rx_valid_i),
        .reprog_i     (reprog_i),
        .iccm_addr_o  (iccm_addr_o),
        .iccm_wdata_o (iccm_wdata_o),
        .iccm_we_o    (iccm_we_o),
        .prog_rst_no  (prog_rst_no),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b);
        logic [31:0] w;
        if (m_done) return;
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
            w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            m_bytes.delete();
            if (w == c_END) begin
                m_done = 1'b1;
            end else begin
                exp_q.push_back({m_count[11:0], w});
                m_count++;
                if (m_count == c_WORDS) m_done = 1'b1;
            end
        end
    endfunction

    function automatic logic [11:0] exp_addr();
        return (m_count >= c_WORDS) ? 12'hFFF : m_count[11:0];
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'($urandom);
        model_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == c_END) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_bytes.delete();
        exp_q.delete();
        m_count = 0;
        m_done  = 1'b0;
    endtask

    task automatic pulse_reprog();
        reprog_i = 1'b1;
        @(posedge clk_i);
        #1;
        reprog_i = 1'b0;
        if (m_done) begin
            m_done  = 1'b0;
            m_count = 0;
            m_bytes.delete();
        end
    endtask

    task automatic check_state(input string name);
        chk({name, "_addr"}, 64'(iccm_addr_o), 64'(exp_addr()));
        chk({name, "_done"}, 64'(done_o), 64'(m_done));
        chk({name, "_prog"}, 64'(prog_rst_no), 64'(m_done));
        chk({name, "_we"}, 64'(iccm_we_o), 64'd0);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("prog_eq_done", 64'(prog_rst_no), 64'(done_o));
            if (iccm_we_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got addr %0h data %0h expected no write",
                             iccm_addr_o, iccm_wdata_o);
                end else begin
                    logic [43:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(iccm_addr_o), 64'(e[43:32]));
                    chk("wr_data", 64'(iccm_wdata_o), 64'(e[31:0]));
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        do_reset();
        chk("rst_addr", 64'(iccm_addr_o), 64'd0);
        chk("rst_wdata", 64'(iccm_wdata_o), 64'd0);
        chk("rst_we", 64'(iccm_we_o), 64'd0);
        chk("rst_prog", 64'(prog_rst_no), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);

        // Single word with gaps between bytes.
        send_byte(8'h13); idle(2);
        send_byte(8'h05); idle(1);
        send_byte(8'h00); idle(3);
        send_byte(8'h00);
        idle(3);
        check_state("first_word");

        // Back-to-back words: next byte 0 lands in the strobe cycle.
        send_word(rand_word(), 0);
        send_word(rand_word(), 0);
        idle(3);
        check_state("b2b");

        // Terminator ends loading on its fourth-byte edge.
        send_byte(8'hFF); send_byte(8'h0F); send_byte(8'h00); send_byte(8'h00);
        chk("term_done_now", 64'(done_o), 64'd1);
        chk("term_prog_now", 64'(prog_rst_no), 64'd1);
        idle(2);
        send_word(rand_word(), 0);
        send_word(rand_word(), 1);
        idle(3);
        check_state("after_term");

        // Restart from DONE.
        pulse_reprog();
        chk("reprog_done", 64'(done_o), 64'd0);
        chk("reprog_prog", 64'(prog_rst_no), 64'd0);
        chk("reprog_addr", 64'(iccm_addr_o), 64'd0);
        send_word(rand_word(), 2);
        idle(3);
        check_state("reprog_word");

        // reprog while loading is ignored; partial bytes survive.
        send_byte(8'h11); send_byte(8'h22);
        pulse_reprog();
        send_byte(8'h33); send_byte(8'h44);
        idle(3);
        check_state("reprog_in_load");

        // Reset discards a partial word.
        send_byte(8'h5A); send_byte(8'hA5);
        do_reset();
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(3);
        check_state("partial_reset");

        // Random words with random spacing.
        for (int i = 0; i < 20; i++) send_word(rand_word(), 2);
        idle(3);
        check_state("random");

        // Fill the whole memory without a terminator.
        do_reset();
        for (int i = 0; i < c_WORDS; i++) send_word(rand_word(), 0);
        send_word(rand_word(), 0);
        idle(3);
        check_state("full");
        pulse_reprog();
        check_state("full_reprog");
        send_word(rand_word(), 1);
        idle(3);
        check_state("full_reprog_word");

        idle(5);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_iccm_ctrl

`default_nettype wire
